// File: rtl/shim_integ_pkg.sv
// Shared types and widths for the shim over-threshold integrator.
package shim_integ_pkg;

    localparam int ACC_W    = 47;
    localparam int ABS_W    = 15;
    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        CHECK,
        FAULT
    } state_t;

endpackage

// File: rtl/shim_integ_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first.
// Operands are captured on start; done pulses MUL_CYCLES cycles later.
module shim_integ_mul
    import shim_integ_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ABS_W-1:0]      a,
    input  logic [MUL_CYCLES-1:0] b,
    output logic                  done,
    output logic [ACC_W-1:0]      product
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    logic [ACC_W-1:0]      mcand_q, mcand_d;
    logic [ACC_W-1:0]      prod_q, prod_d;
    logic [MUL_CYCLES-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // A new start restarts the multiply even if one is in flight.
        if (start) begin
            mcand_d  = ACC_W'(a);
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/shim_threshold_integrator.sv
// Per-channel |DAC| integrator with windowed over-threshold check.
// Raises a sticky fault to the shim shutdown logic when any window sum exceeds thresh*window.
module shim_threshold_integrator
    import shim_integ_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int MUL_CYCLES = 32
) (
    input  logic                         spi_clk,
    input  logic                         resetn,
    input  logic [ABS_W-1:0]             integ_thresh_avg,
    input  logic [MUL_CYCLES-1:0]        integ_window,
    input  logic                         integ_en,
    input  logic                         spi_en,
    input  logic [CHANNELS*SAMPLE_W-1:0] dac_value,
    output logic                         running,
    output logic                         window_done,
    output logic                         over_thresh,
    output logic [CHANNELS-1:0]          over_thresh_ch,
    output logic                         err_window_zero
);

    state_t                state_q, state_d;
    logic [MUL_CYCLES-1:0] win_q, win_d;
    logic [MUL_CYCLES-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]      limit_q, limit_d;
    logic                  window_done_q, window_done_d;
    logic                  over_q, over_d;
    logic [CHANNELS-1:0]   och_q, och_d;
    logic                  err_q, err_d;

    logic                  active, go, win_last, any_flag;
    logic                  acc_add, acc_hold, acc_clr;
    logic                  mul_start, mul_done;
    logic [ACC_W-1:0]      mul_prod;
    logic [CHANNELS-1:0]   flags;

    // -32768 has no 15-bit magnitude, so it saturates to full scale.
    function automatic logic [ABS_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
        if (x[SAMPLE_W-1] && (x[SAMPLE_W-2:0] == '0)) begin
            return '1;
        end else if (x[SAMPLE_W-1]) begin
            return ABS_W'(-x);
        end else begin
            return x[ABS_W-1:0];
        end
    endfunction

    assign active   = integ_en && spi_en;
    assign go       = active && !over_q && !err_q;
    assign win_last = (cnt_q == win_q - 1'b1);
    assign any_flag = |flags;

    assign mul_start = (state_q == IDLE) && go;

    shim_integ_mul #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul (
        .clk    (spi_clk),
        .rst_n  (resetn),
        .start  (mul_start),
        .a      (integ_thresh_avg),
        .b      (integ_window),
        .done   (mul_done),
        .product(mul_prod)
    );

    always_ff @(posedge spi_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (go) state_d = SETUP;
            SETUP: begin
                if (!active || (win_q == '0)) state_d = IDLE;
                else if (mul_done)            state_d = RUN;
            end
            RUN: begin
                if (!active)      state_d = IDLE;
                else if (win_last) state_d = CHECK;
            end
            // A fault found in CHECK wins over a simultaneous loss of enable.
            CHECK: begin
                if (any_flag)     state_d = FAULT;
                else if (!active) state_d = IDLE;
                else              state_d = RUN;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_d         = win_q;
        limit_d       = limit_q;
        err_d         = err_q;
        over_d        = over_q;
        och_d         = och_q;
        cnt_d         = '0;
        window_done_d = 1'b0;
        if (mul_start) begin
            win_d = integ_window;
        end
        if ((state_q == SETUP) && active && (win_q == '0)) begin
            err_d = 1'b1;
        end
        if ((state_q == SETUP) && active && mul_done) begin
            limit_d = mul_prod;
        end
        if ((state_q == RUN) && active) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == CHECK) begin
            if (any_flag) begin
                over_d = 1'b1;
                och_d  = och_q | flags;
            end else begin
                window_done_d = active;
            end
        end
        acc_add  = (state_q == RUN) && active;
        acc_hold = (state_q == FAULT) || ((state_q == CHECK) && any_flag);
        acc_clr  = !acc_add && !acc_hold;
    end

    always_ff @(posedge spi_clk or negedge resetn) begin
        if (!resetn) begin
            win_q         <= '0;
            limit_q       <= '0;
            err_q         <= 1'b0;
            over_q        <= 1'b0;
            och_q         <= '0;
            cnt_q         <= '0;
            window_done_q <= 1'b0;
        end else begin
            win_q         <= win_d;
            limit_q       <= limit_d;
            err_q         <= err_d;
            over_q        <= over_d;
            och_q         <= och_d;
            cnt_q         <= cnt_d;
            window_done_q <= window_done_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ABS_W-1:0] mag;

        assign mag = abs_sat(dac_value[k*SAMPLE_W +: SAMPLE_W]);

        always_comb begin
            acc_d = acc_q;
            if (acc_clr) begin
                acc_d = '0;
            end else if (acc_add) begin
                acc_d = acc_q + ACC_W'(mag);
            end
        end

        always_ff @(posedge spi_clk or negedge resetn) begin
            if (!resetn) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end

        // Strictly greater: a sum equal to the limit is still in range.
        assign flags[k] = (acc_q > limit_q);
    end

    assign running         = (state_q == RUN);
    assign window_done     = window_done_q;
    assign over_thresh     = over_q;
    assign over_thresh_ch  = och_q;
    assign err_window_zero = err_q;

endmodule

// File: tb/tb_shim_threshold_integrator.sv
// Scoreboard bench: drivers push expected window outcomes, a negedge monitor pops and checks them.
module tb_shim_threshold_integrator;

    localparam int CH = 8;

    logic            spi_clk = 1'b0;
    logic            resetn;
    logic [14:0]     integ_thresh_avg;
    logic [31:0]     integ_window;
    logic            integ_en;
    logic            spi_en;
    logic [CH*16-1:0] dac_value;
    logic            running;
    logic            window_done;
    logic            over_thresh;
    logic [CH-1:0]   over_thresh_ch;
    logic            err_window_zero;

    shim_threshold_integrator #(.CHANNELS(CH), .MUL_CYCLES(32)) dut (
        .spi_clk         (spi_clk),
        .resetn          (resetn),
        .integ_thresh_avg(integ_thresh_avg),
        .integ_window    (integ_window),
        .integ_en        (integ_en),
        .spi_en          (spi_en),
        .dac_value       (dac_value),
        .running         (running),
        .window_done     (window_done),
        .over_thresh     (over_thresh),
        .over_thresh_ch  (over_thresh_ch),
        .err_window_zero (err_window_zero)
    );

    always #5 spi_clk = ~spi_clk;

    typedef struct {
        bit          is_fault;
        logic [CH-1:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   const_val[CH];
    int   cfg_thr, cfg_win;
    logic ot_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every DUT result event consumes one scoreboard entry.
    always @(negedge spi_clk) begin
        exp_t e;
        if (window_done) begin
            check("window_done has pending entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("window_done on passing window", e.is_fault, 0);
            end
        end
        if (over_thresh && !ot_prev) begin
            check("over_thresh has pending entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("over_thresh on faulting window", e.is_fault, 1);
                check("over_thresh_ch mask", over_thresh_ch, e.mask);
            end
        end
        ot_prev <= over_thresh;
    end

    function automatic int abs_ref(input int v);
        if (v < -32767) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int gen(input int mode, input int k);
        int r, mag;
        if (mode == 0) return const_val[k];
        r   = $urandom_range(0, 15);
        mag = (r == 0) ? cfg_thr + 1 : cfg_thr - (r % 3);
        if (mag > 32767) mag = 32767;
        if (mag < 0) mag = 0;
        if ($urandom_range(0, 1) == 1) begin
            if (mag == 32767 && $urandom_range(0, 1) == 1) return -32768;
            return -mag;
        end
        return mag;
    endfunction

    task automatic set_all(input int v);
        for (int k = 0; k < CH; k++) dac_value[k*16 +: 16] = 16'(v);
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        integ_en = 1'b0;
        spi_en   = 1'b0;
        set_all(0);
        repeat (2) @(negedge spi_clk);
        resetn = 1'b1;
        @(negedge spi_clk);
    endtask

    // Called at a negedge with the DUT idle; raising active enters SETUP at the next edge.
    task automatic start_setup(input int thr, input int win, input bit expect_run);
        int n;
        cfg_thr          = thr;
        cfg_win          = win;
        integ_thresh_avg = 15'(thr);
        integ_window     = 32'(win);
        integ_en         = 1'b1;
        spi_en           = 1'b1;
        if (expect_run) begin
            n = 0;
            do begin
                @(negedge spi_clk);
                n++;
            end while (!running && n < 60);
            check("enable-to-RUN latency (1 + 33 setup)", n, 34);
        end
    endtask

    // Starts at the first RUN negedge; returns at the CHECK negedge of the last window issued.
    task automatic run_windows(input int nwin, input int mode, input bit chg_thr, output bit faulted);
        longint sums[CH];
        exp_t   e;
        int     v;
        faulted = 1'b0;
        for (int w = 0; w < nwin; w++) begin
            for (int k = 0; k < CH; k++) sums[k] = 0;
            for (int s = 0; s < cfg_win; s++) begin
                if (s > 0) @(negedge spi_clk);
                check("running while sampling", running, 1);
                if (chg_thr && w == 0 && s == 0) integ_thresh_avg = 15'd1;
                for (int k = 0; k < CH; k++) begin
                    v = gen(mode, k);
                    dac_value[k*16 +: 16] = 16'(v);
                    sums[k] += abs_ref(v);
                end
            end
            @(negedge spi_clk);
            check("running low in CHECK", running, 0);
            set_all(32767);
            e.is_fault = 1'b0;
            e.mask     = '0;
            for (int k = 0; k < CH; k++) begin
                if (sums[k] > longint'(cfg_thr) * cfg_win) begin
                    e.mask[k]  = 1'b1;
                    e.is_fault = 1'b1;
                end
            end
            exp_q.push_back(e);
            if (e.is_fault) begin
                faulted = 1'b1;
                return;
            end
            if (w < nwin - 1) @(negedge spi_clk);
        end
    endtask

    task automatic drain();
        @(negedge spi_clk);
        integ_en = 1'b0;
        set_all(0);
        repeat (3) @(negedge spi_clk);
        check("scoreboard empty", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit f;
        int cnt;
        resetn           = 1'b0;
        integ_thresh_avg = '0;
        integ_window     = '0;
        integ_en         = 1'b0;
        spi_en           = 1'b0;
        dac_value        = '0;
        repeat (2) @(negedge spi_clk);
        check("reset running", running, 0);
        check("reset window_done", window_done, 0);
        check("reset over_thresh", over_thresh, 0);
        check("reset over_thresh_ch", over_thresh_ch, 0);
        check("reset err_window_zero", err_window_zero, 0);
        resetn = 1'b1;
        @(negedge spi_clk);

        // All channels exactly at the average: sum equals limit, never faults.
        for (int k = 0; k < CH; k++) const_val[k] = 100;
        start_setup(100, 4, 1);
        run_windows(3, 0, 0, f);
        drain();
        check("equal-to-limit gives no fault", over_thresh, 0);

        // Channel 3 one count over: fault on first CHECK, held through enable toggles.
        do_reset();
        const_val[3] = -101;
        start_setup(100, 4, 1);
        run_windows(3, 0, 0, f);
        @(negedge spi_clk);
        for (int i = 0; i < 6; i++) begin
            integ_en = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge spi_clk);
            check("fault held over_thresh", over_thresh, 1);
            check("fault held mask", over_thresh_ch, 8'h08);
        end
        integ_en = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge spi_clk);
            if (running) cnt++;
        end
        check("no re-entry after fault", cnt, 0);
        check("scoreboard empty after fault", exp_q.size(), 0);
        resetn = 1'b0;
        #1;
        check("async reset clears over_thresh", over_thresh, 0);
        check("async reset clears mask", over_thresh_ch, 0);
        do_reset();

        // Zero window: error one cycle after SETUP entry, sticky, no RUN.
        start_setup(50, 0, 0);
        @(negedge spi_clk);
        check("err_window_zero not yet set", err_window_zero, 0);
        @(negedge spi_clk);
        check("err_window_zero set", err_window_zero, 1);
        cnt = 0;
        repeat (20) begin
            @(negedge spi_clk);
            if (running) cnt++;
        end
        integ_en = 1'b0;
        @(negedge spi_clk);
        integ_en = 1'b1;
        repeat (40) begin
            @(negedge spi_clk);
            if (running) cnt++;
        end
        check("running never asserts with zero window", cnt, 0);
        check("err_window_zero sticky", err_window_zero, 1);

        // -32768 saturates to 32767: 2 samples equal the limit 32767*2.
        do_reset();
        for (int k = 0; k < CH; k++) const_val[k] = 0;
        const_val[0] = -32768;
        start_setup(32767, 2, 1);
        run_windows(3, 0, 0, f);
        drain();
        check("saturated sample at limit no fault", over_thresh, 0);
        do_reset();
        start_setup(32766, 2, 1);
        run_windows(3, 0, 0, f);
        drain();
        check("saturated sample over limit mask", over_thresh_ch, 8'h01);

        // Drop spi_en mid-window, then restart with a new config.
        do_reset();
        for (int k = 0; k < CH; k++) const_val[k] = 50;
        set_all(50);
        start_setup(100, 10, 1);
        repeat (2) @(negedge spi_clk);
        spi_en = 1'b0;
        @(negedge spi_clk);
        check("abort to IDLE running", running, 0);
        check("abort no over_thresh", over_thresh, 0);
        check("abort no mask", over_thresh_ch, 0);
        check("abort no window_done", window_done, 0);
        repeat (2) @(negedge spi_clk);
        for (int k = 0; k < CH; k++) const_val[k] = 5;
        const_val[6] = 6;
        start_setup(5, 3, 1);
        run_windows(2, 0, 0, f);
        drain();
        check("new config latched on re-entry", over_thresh_ch, 8'h40);

        // Threshold change during RUN must not affect the latched limit.
        do_reset();
        for (int k = 0; k < CH; k++) const_val[k] = 100;
        start_setup(100, 4, 1);
        run_windows(3, 0, 1, f);
        drain();
        check("mid-run threshold change ignored", over_thresh, 0);

        // Randomised configs with samples clustered around the threshold.
        for (int it = 0; it < 10; it++) begin
            int thr;
            do_reset();
            thr = ($urandom_range(0, 3) == 0) ? $urandom_range(32760, 32767) : $urandom_range(0, 2000);
            start_setup(thr, $urandom_range(1, 6), 1);
            run_windows(5, 1, 0, f);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shim_threshold_integrator.md
Name: shim_threshold_integrator

Overview:
- Consumer of the SPI-domain stable config outputs: integ_thresh_avg_stable, integ_window_stable, integ_en_stable and spi_en_stable.
- Runs one accumulator per DAC channel on the absolute value of the DAC words sent over SPI.
- At the end of every integration window, compares each channel's sum against the limit integ_thresh_avg × integ_window.
- Raises a sticky over-threshold fault to the shim safety/shutdown logic.

Parameters:
CHANNELS, 8, number of DAC channels integrated in parallel
MUL_CYCLES, 32, shift-add multiplier iterations; equals integ_window width, fixed

Ports:
spi_clk  in  1  SPI-domain clock
resetn  in  1  asynchronous active-low reset
integ_thresh_avg  in  15  per-sample average threshold (unsigned), from config sync stage
integ_window  in  32  window length in spi_clk cycles, from config sync stage
integ_en  in  1  integration enable, from config sync stage
spi_en  in  1  SPI subsystem enable, from config sync stage
dac_value  in  CHANNELS*16  packed signed 16-bit DAC words; channel k at [16k+15:16k]
running  out  1  high in RUN state
window_done  out  1  one-cycle pulse when a window passes its check with no fault
over_thresh  out  1  sticky fault flag
over_thresh_ch  out  CHANNELS  sticky per-channel fault mask
err_window_zero  out  1  sticky flag set when integ_window==0 at setup

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs, accumulators, counter and limit register are 0.
- Gating: active = integ_en && spi_en.
- Absolute value: abs(x) is 15 bits unsigned. -32768 saturates to 32767.
- Accumulators: 47 bits per channel, which cannot overflow for window ≤ 2^32−1.
- IDLE:
  - if active and no sticky flag is set → SETUP.
  - On SETUP entry, latch integ_thresh_avg and integ_window; later config changes are ignored until the next SETUP.
- SETUP:
  - If the latched window is 0: set err_window_zero → IDLE, which then holds.
  - Otherwise compute limit = thresh × window with a sequential shift-add multiplier: one bit per cycle, LSB first, 32 cycles. Limit width is 47 bits.
  - Clear all accumulators and the window counter, then → RUN.
  - SETUP→RUN latency: 33 cycles after SETUP entry.
- RUN:
  - Each cycle, acc[k] += abs(dac_value[k]) for all k, and the counter increments.
  - When counter == window−1, the sample is added that cycle → CHECK.
- CHECK (one cycle, no sampling):
  - Per channel, flag[k] = acc[k] > limit. Strict greater-than: equal does not fault.
  - If any flag is set: set over_thresh and OR the flags into over_thresh_ch → FAULT.
  - Else: pulse window_done, clear accumulators and counter → RUN.
  - Effective window period is window+1 cycles.
- FAULT: terminal. Flags are held and no accumulation happens. Only resetn clears the fault; deasserting active does not.
- Deassert active in SETUP/RUN/CHECK:
  - Next cycle → IDLE with accumulators cleared and no flag changes.
  - Exception: a CHECK that detects a fault in the same cycle gives the fault priority.
- Simultaneous: in CHECK with active falling, the fault result is still recorded.
- err_window_zero is sticky until reset and blocks re-entry to SETUP.
- running = (state==RUN).

Decomposition:
- Shared package shim_integ_pkg:
  - state enum {IDLE, SETUP, RUN, CHECK, FAULT}
  - ACC_W=47, ABS_W=15, SAMPLE_W=16
- Sub-module shim_integ_mul: a 15×32 sequential shift-add multiplier.
  - Ports: start, done, 47-bit product.
  - Latency MUL_CYCLES.
  - Asynchronous active-low reset.
- Per-channel abs/accumulate/compare logic is a generate loop in the top level, not a separate module.

Test Plan:
- Reset, then active=1 with thresh=100, window=4, all channels at +100 → 33 setup cycles, then window_done pulses every 5 cycles; over_thresh stays 0 because 400 is not > 400.
- Same config, channel 3 = −101 → at the first CHECK, over_thresh=1 and over_thresh_ch=8'b0000_1000; state stays FAULT while integ_en toggles; cleared only by resetn.
- Window=0 with active=1 → err_window_zero=1 one cycle after SETUP entry; running never asserts.
- Channel 0 = −32768, thresh=32767, window=2 → sum 65534 equals limit, so no fault; thresh=32766 → fault on channel 0.
- Drop spi_en mid-RUN at counter=2 of window=10 → IDLE next cycle with no flags set; re-raise → fresh SETUP using the new config values latched at re-entry.
- Change integ_thresh_avg from 100 to 1 during RUN → no effect on the current limit until the next SETUP.
